// File: rtl/instr_trace_buf.sv
// rtl/instr_trace_buf.sv - retired-instruction trace buffer with mask/match trigger and indexed readback
module instr_trace_buf #(
    parameter int DEPTH     = 16,
    parameter int PC_W      = 32,
    parameter int CHARS     = 6,
    parameter int TRIG_POST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    input  logic [PC_W-1:0]          wb_pc,
    input  logic [31:0]              wb_instr,
    input  logic                     trig_en,
    input  logic [31:0]              trig_mask,
    input  logic [31:0]              trig_match,
    input  logic                     arm,
    input  logic                     rd_req,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic                     rd_ack,
    output logic                     rd_err,
    output logic [PC_W-1:0]          rd_pc,
    output logic [31:0]              rd_instr,
    output logic [8*CHARS-1:0]       rd_ascii,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               state,
    output logic [15:0]              unknown_cnt
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_ARMED  = 2'd0;
    localparam logic [1:0] S_POST   = 2'd1;
    localparam logic [1:0] S_FROZEN = 2'd2;

    localparam logic [AW:0]   FULL   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] POST_N = AW'(TRIG_POST);
    localparam logic [63:0]   MN_NR  = "N-R     ";

    logic [PC_W-1:0]    mem_pc    [DEPTH];
    logic [31:0]        mem_instr [DEPTH];
    logic [8*CHARS-1:0] mem_ascii [DEPTH];

    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      post_cnt;
    logic [63:0]        mn;
    logic               unk;
    logic [8*CHARS-1:0] wr_ascii;
    logic               wr_en;
    logic               trig_hit;
    logic [AW-1:0]      rd_base;
    logic [AW-1:0]      rd_slot;
    logic               rd_oob;

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] funct;

    assign op    = wb_instr[31:26];
    assign rs    = wb_instr[25:21];
    assign rt    = wb_instr[20:16];
    assign funct = wb_instr[5:0];

    // Mnemonics are held as 8 space-padded characters, then fitted to CHARS below
    always_comb begin
        mn = MN_NR;
        if (wb_instr == 32'h0000_0000) begin
            mn = "NOP     ";
        end else if (wb_instr == 32'h4200_0018) begin
            mn = "ERET    ";
        end else begin
            case (op)
                6'h00: begin
                    case (funct)
                        6'h00: mn = "SLL     ";
                        6'h02: mn = "SRL     ";
                        6'h03: mn = "SRA     ";
                        6'h04: mn = "SLLV    ";
                        6'h06: mn = "SRLV    ";
                        6'h07: mn = "SRAV    ";
                        6'h08: mn = "JR      ";
                        6'h09: mn = "JALR    ";
                        6'h0C: mn = "SYSCALL ";
                        6'h0D: mn = "BREAK   ";
                        6'h10: mn = "MFHI    ";
                        6'h11: mn = "MTHI    ";
                        6'h12: mn = "MFLO    ";
                        6'h13: mn = "MTLO    ";
                        6'h18: mn = "MULT    ";
                        6'h19: mn = "MULTU   ";
                        6'h1A: mn = "DIV     ";
                        6'h1B: mn = "DIVU    ";
                        6'h20: mn = "ADD     ";
                        6'h21: mn = "ADDU    ";
                        6'h22: mn = "SUB     ";
                        6'h23: mn = "SUBU    ";
                        6'h24: mn = "AND     ";
                        6'h25: mn = "OR      ";
                        6'h26: mn = "XOR     ";
                        6'h27: mn = "NOR     ";
                        6'h2A: mn = "SLT     ";
                        6'h2B: mn = "SLTU    ";
                        default: mn = MN_NR;
                    endcase
                end
                6'h01: begin
                    case (rt)
                        5'h00: mn = "BLTZ    ";
                        5'h01: mn = "BGEZ    ";
                        5'h10: mn = "BLTZAL  ";
                        5'h11: mn = "BGEZAL  ";
                        default: mn = MN_NR;
                    endcase
                end
                6'h02: mn = "J       ";
                6'h03: mn = "JAL     ";
                6'h04: mn = "BEQ     ";
                6'h05: mn = "BNE     ";
                6'h06: mn = "BLEZ    ";
                6'h07: mn = "BGTZ    ";
                6'h08: mn = "ADDI    ";
                6'h09: mn = "ADDIU   ";
                6'h0A: mn = "SLTI    ";
                6'h0B: mn = "SLTIU   ";
                6'h0C: mn = "ANDI    ";
                6'h0D: mn = "ORI     ";
                6'h0E: mn = "XORI    ";
                6'h0F: mn = "LUI     ";
                6'h10: begin
                    case (rs)
                        5'h00: mn = "MFC0    ";
                        5'h04: mn = "MTC0    ";
                        default: mn = MN_NR;
                    endcase
                end
                6'h20: mn = "LB      ";
                6'h21: mn = "LH      ";
                6'h23: mn = "LW      ";
                6'h24: mn = "LBU     ";
                6'h25: mn = "LHU     ";
                6'h28: mn = "SB      ";
                6'h29: mn = "SH      ";
                6'h2B: mn = "SW      ";
                default: mn = MN_NR;
            endcase
        end
    end

    assign unk = (mn == MN_NR);

    always_comb begin
        wr_ascii = '0;
        for (int i = 0; i < CHARS; i++) begin
            if (i < 8) begin
                wr_ascii[8*(CHARS-1-i) +: 8] = mn[8*(7-i) +: 8];
            end else begin
                wr_ascii[8*(CHARS-1-i) +: 8] = 8'h20;
            end
        end
    end

    assign wr_en    = wb_valid && (state != S_FROZEN) && !arm;
    assign trig_hit = trig_en && ((wb_instr & trig_mask) == (trig_match & trig_mask));

    // Once the buffer has wrapped, the oldest entry sits at the write pointer
    assign rd_base = (count == FULL) ? wr_ptr : '0;
    assign rd_slot = rd_base + rd_idx;
    assign rd_oob  = ({1'b0, rd_idx} >= count);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pc[wr_ptr]    <= wb_pc;
            mem_instr[wr_ptr] <= wb_instr;
            mem_ascii[wr_ptr] <= wr_ascii;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ack      <= 1'b0;
            rd_err      <= 1'b0;
            rd_pc       <= '0;
            rd_instr    <= '0;
            rd_ascii    <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            post_cnt    <= '0;
            state       <= S_ARMED;
            unknown_cnt <= '0;
        end else begin
            rd_ack <= rd_req;
            if (rd_req) begin
                rd_err <= rd_oob;
                if (rd_oob) begin
                    rd_pc    <= '0;
                    rd_instr <= '0;
                    rd_ascii <= '0;
                end else begin
                    rd_pc    <= mem_pc[rd_slot];
                    rd_instr <= mem_instr[rd_slot];
                    rd_ascii <= mem_ascii[rd_slot];
                end
            end

            if (arm) begin
                wr_ptr      <= '0;
                count       <= '0;
                post_cnt    <= '0;
                state       <= S_ARMED;
                unknown_cnt <= '0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (count != FULL) begin
                    count <= count + 1'b1;
                end
                if (unk && (unknown_cnt != 16'hFFFF)) begin
                    unknown_cnt <= unknown_cnt + 16'd1;
                end
                case (state)
                    S_ARMED: begin
                        if (trig_hit) begin
                            if (TRIG_POST == 0) begin
                                state <= S_FROZEN;
                            end else begin
                                state    <= S_POST;
                                post_cnt <= POST_N;
                            end
                        end
                    end
                    S_POST: begin
                        post_cnt <= post_cnt - 1'b1;
                        if (post_cnt == 1) begin
                            state <= S_FROZEN;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_trace_buf.sv
// tb/tb_instr_trace_buf.sv - scoreboard bench for instr_trace_buf
module tb_instr_trace_buf;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wb_valid = 1'b0;
    logic [31:0]   wb_pc = '0;
    logic [31:0]   wb_instr = '0;
    logic          trig_en = 1'b0;
    logic [31:0]   trig_mask = '0;
    logic [31:0]   trig_match = '0;
    logic          arm = 1'b0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_idx = '0;
    logic          rd_ack;
    logic          rd_err;
    logic [31:0]   rd_pc;
    logic [31:0]   rd_instr;
    logic [47:0]   rd_ascii;
    logic [AW:0]   count;
    logic [1:0]    state;
    logic [15:0]   unknown_cnt;

    instr_trace_buf #(.DEPTH(16), .PC_W(32), .CHARS(6), .TRIG_POST(4)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr),
        .trig_en(trig_en), .trig_mask(trig_mask), .trig_match(trig_match), .arm(arm),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(rd_ack), .rd_err(rd_err),
        .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_ascii(rd_ascii), .count(count),
        .state(state), .unknown_cnt(unknown_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [47:0] asc;
    } ent_t;

    typedef struct packed {
        logic err;
        ent_t e;
    } rd_t;

    ent_t hist[$];
    rd_t  sb[$];
    int   checks = 0;
    int   failures = 0;

    function automatic rd_t model_read(input int idx);
        rd_t r;
        r = '0;
        if (idx < hist.size()) r.e = hist[idx];
        else r.err = 1'b1;
        return r;
    endfunction

    task automatic wr(input logic [31:0] pc, input logic [31:0] ins, input logic [47:0] asc, input bit rec);
        ent_t e;
        @(negedge clk);
        wb_valid = 1'b1;
        wb_pc = pc;
        wb_instr = ins;
        @(negedge clk);
        wb_valid = 1'b0;
        if (rec) begin
            e.pc = pc;
            e.instr = ins;
            e.asc = asc;
            hist.push_back(e);
            if (hist.size() > DEPTH) void'(hist.pop_front());
        end
    endtask

    task automatic do_arm();
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        hist.delete();
    endtask

    // Back-to-back requests; each ack is popped from the scoreboard on the following cycle
    task automatic reads(input int lo, input int n, input string tag);
        rd_t ex;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                ex = sb.pop_front();
                checks++;
                if (rd_ack !== 1'b1 || rd_err !== ex.err || rd_pc !== ex.e.pc ||
                    rd_instr !== ex.e.instr || rd_ascii !== ex.e.asc) begin
                    failures++;
                    $display("FAIL %s idx%0d: ack=%b err=%b pc=%h instr=%h ascii=\"%s\" expected ack=1 err=%b pc=%h instr=%h ascii=\"%s\"",
                             tag, lo + i - 1, rd_ack, rd_err, rd_pc, rd_instr, rd_ascii,
                             ex.err, ex.e.pc, ex.e.instr, ex.e.asc);
                end
            end
            if (i < n) begin
                rd_req = 1'b1;
                rd_idx = AW'(lo + i);
                sb.push_back(model_read(lo + i));
            end else begin
                rd_req = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (rd_ack !== 1'b0) begin
            failures++;
            $display("FAIL %s ack_idle: ack=%b expected 0", tag, rd_ack);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rd_ack, rd_err, rd_pc, rd_instr, rd_ascii, count, state, unknown_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ack=%b err=%b pc=%h count=%0d state=%0d unk=%0d expected all 0",
                     rd_ack, rd_err, rd_pc, count, state, unknown_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        wr(32'h100, 32'h0000_0000, "NOP   ", 1);
        wr(32'h104, 32'h4200_0018, "ERET  ", 1);
        wr(32'h108, 32'h0411_0003, "BGEZAL", 1);
        checks++;
        if (count !== 5'd3) begin
            failures++;
            $display("FAIL basic_count: count=%0d expected 3", count);
        end
        reads(0, 4, "basic");
    endtask

    task automatic test_wrap();
        do_arm();
        for (int k = 0; k < 20; k++) begin
            case (k % 3)
                0: wr(32'(4 * k), 32'h2442_0001, "ADDIU ", 1);
                1: wr(32'(4 * k), 32'h8C43_0000, "LW    ", 1);
                default: wr(32'(4 * k), 32'hAC43_0004, "SW    ", 1);
            endcase
        end
        checks++;
        if (count !== 5'd16) begin
            failures++;
            $display("FAIL wrap_count: count=%0d expected 16", count);
        end
        checks++;
        if (hist[0].pc !== 32'h10 || hist[15].pc !== 32'h4C) begin
            failures++;
            $display("FAIL wrap_model: idx0 pc=%h idx15 pc=%h expected 10 and 4c", hist[0].pc, hist[15].pc);
        end
        reads(0, 16, "wrap");
    endtask

    task automatic test_trigger();
        do_arm();
        trig_en = 1'b1;
        trig_mask = 32'hFC00_0000;
        trig_match = 32'h0800_0000;
        for (int k = 1; k <= 12; k++) begin
            if (k == 5 || k == 7) wr(32'h500 + 32'(4 * k), 32'h0800_0040, "J     ", k <= 9);
            else wr(32'h500 + 32'(4 * k), 32'h3421_0001, "ORI   ", k <= 9);
            if (k == 4 || k == 5 || k == 8 || k == 9 || k == 12) begin
                checks++;
                if (state !== ((k < 5) ? 2'd0 : (k < 9) ? 2'd1 : 2'd2)) begin
                    failures++;
                    $display("FAIL trig_state after write %0d: state=%0d expected %0d",
                             k, state, (k < 5) ? 0 : (k < 9) ? 1 : 2);
                end
            end
        end
        trig_en = 1'b0;
        checks++;
        if (count !== 5'd9) begin
            failures++;
            $display("FAIL trig_count: count=%0d expected 9", count);
        end
        reads(0, 10, "trigger");
    endtask

    task automatic test_unknown();
        do_arm();
        wr(32'h600, 32'hFC00_0000, "N-R   ", 1);
        wr(32'h604, 32'hFC00_0000, "N-R   ", 1);
        wr(32'h608, 32'h041F_0000, "N-R   ", 1);
        wr(32'h60C, 32'h0000_000C, "SYSCAL", 1);
        checks++;
        if (unknown_cnt !== 16'd3) begin
            failures++;
            $display("FAIL unknown_cnt: got %0d expected 3", unknown_cnt);
        end
        reads(0, 4, "unknown");
    endtask

    task automatic test_arm_frozen();
        do_arm();
        trig_en = 1'b1;
        trig_mask = 32'h0;
        trig_match = 32'h0;
        wr(32'h700, 32'hFC00_0000, "N-R   ", 1);
        for (int k = 1; k < 5; k++) wr(32'h700 + 32'(4 * k), 32'h4002_6000, "MFC0  ", 1);
        wr(32'h7F0, 32'h4082_6000, "MTC0  ", 0);
        checks++;
        if (state !== 2'd2 || count !== 5'd5 || unknown_cnt !== 16'd1) begin
            failures++;
            $display("FAIL frozen: state=%0d count=%0d unk=%0d expected 2 5 1", state, count, unknown_cnt);
        end
        @(negedge clk);
        arm = 1'b1;
        wb_valid = 1'b1;
        wb_pc = 32'h999;
        wb_instr = 32'hFC00_0000;
        @(negedge clk);
        arm = 1'b0;
        wb_valid = 1'b0;
        trig_en = 1'b0;
        hist.delete();
        checks++;
        if (state !== 2'd0 || count !== 5'd0 || unknown_cnt !== 16'd0) begin
            failures++;
            $display("FAIL arm_clear: state=%0d count=%0d unk=%0d expected 0 0 0", state, count, unknown_cnt);
        end
        wr(32'h200, 32'h0022_1821, "ADDU  ", 1);
        checks++;
        if (count !== 5'd1) begin
            failures++;
            $display("FAIL arm_next_count: count=%0d expected 1", count);
        end
        reads(0, 1, "after_arm");
    endtask

    task automatic test_same_slot();
        ent_t old_e;
        ent_t new_e;
        do_arm();
        for (int k = 0; k < 16; k++) begin
            if (k[0]) wr(32'h1000 + 32'(4 * k), 32'h4082_6000, "MTC0  ", 1);
            else wr(32'h1000 + 32'(4 * k), 32'h4002_6000, "MFC0  ", 1);
        end
        old_e = hist[0];
        new_e.pc = 32'h2000;
        new_e.instr = 32'h0000_000D;
        new_e.asc = "BREAK ";
        @(negedge clk);
        rd_req = 1'b1;
        rd_idx = '0;
        wb_valid = 1'b1;
        wb_pc = new_e.pc;
        wb_instr = new_e.instr;
        @(negedge clk);
        rd_req = 1'b0;
        wb_valid = 1'b0;
        checks++;
        if (rd_ack !== 1'b1 || rd_err !== 1'b0 || rd_pc !== old_e.pc || rd_instr !== old_e.instr || rd_ascii !== old_e.asc) begin
            failures++;
            $display("FAIL same_slot: ack=%b err=%b pc=%h instr=%h expected ack=1 err=0 pc=%h instr=%h",
                     rd_ack, rd_err, rd_pc, rd_instr, old_e.pc, old_e.instr);
        end
        hist.push_back(new_e);
        void'(hist.pop_front());
        reads(15, 1, "newest");
        reads(0, 1, "oldest_after");
    endtask

    task automatic test_rst_post();
        do_arm();
        trig_en = 1'b1;
        trig_mask = 32'h0;
        wr(32'h300, 32'h3421_0001, "ORI   ", 1);
        trig_en = 1'b0;
        @(negedge clk);
        rd_req = 1'b1;
        rd_idx = '0;
        @(negedge clk);
        rd_req = 1'b0;
        checks++;
        if (state !== 2'd1 || rd_ack !== 1'b1 || rd_pc !== 32'h300) begin
            failures++;
            $display("FAIL pre_rst: state=%0d ack=%b pc=%h expected 1 1 300", state, rd_ack, rd_pc);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rd_ack, rd_err, rd_pc, rd_instr, rd_ascii, count, state, unknown_cnt} !== '0) begin
            failures++;
            $display("FAIL rst_mid_post: ack=%b pc=%h count=%0d state=%0d expected all 0", rd_ack, rd_pc, count, state);
        end
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
        wr(32'h400, 32'h3C01_1234, "LUI   ", 1);
        checks++;
        if (count !== 5'd1 || state !== 2'd0) begin
            failures++;
            $display("FAIL post_rst_write: count=%0d state=%0d expected 1 0", count, state);
        end
        reads(0, 1, "post_rst");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_trigger();
        test_unknown();
        test_arm_frozen();
        test_same_slot();
        test_rst_post();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
